// File: rtl/and_snina_ctrl_if.sv
// Bundle of request, randomness, gadget and result signals around the masked AND controller.
// The slave modport is the controller's view; master is the surrounding environment.
interface and_snina_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_a_0, req_a_1, req_a_2;
    logic [2:0] req_b_0, req_b_1, req_b_2;
    logic       rnd_req;
    logic       rnd_valid;
    logic [2:0] rnd_data;
    logic [2:0] g_a_0, g_a_1, g_a_2;
    logic [2:0] g_b_0, g_b_1, g_b_2;
    logic [2:0] g_r;
    logic [2:0] g_c_0, g_c_1, g_c_2;
    logic       g_ok_0, g_ok_1, g_ok_2;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_c_0, out_c_1, out_c_2;
    logic       busy;
    logic       alarm;

    modport slave (
        input  req_valid, req_a_0, req_a_1, req_a_2, req_b_0, req_b_1, req_b_2,
        input  rnd_valid, rnd_data,
        input  g_c_0, g_c_1, g_c_2, g_ok_0, g_ok_1, g_ok_2,
        input  out_ready,
        output req_ready, rnd_req,
        output g_a_0, g_a_1, g_a_2, g_b_0, g_b_1, g_b_2, g_r,
        output out_valid, out_c_0, out_c_1, out_c_2, busy, alarm
    );

    modport master (
        output req_valid, req_a_0, req_a_1, req_a_2, req_b_0, req_b_1, req_b_2,
        output rnd_valid, rnd_data,
        output g_c_0, g_c_1, g_c_2, g_ok_0, g_ok_1, g_ok_2,
        output out_ready,
        input  req_ready, rnd_req,
        input  g_a_0, g_a_1, g_a_2, g_b_0, g_b_1, g_b_2, g_r,
        input  out_valid, out_c_0, out_c_1, out_c_2, busy, alarm
    );
endinterface

// File: rtl/and_snina_ctrl.sv
// Sequencer for a 3-share masked AND gadget: captures operands and fresh mask, waits out the
// gadget latency, checks replica consistency and either hands the result out or latches an alarm.
module and_snina_ctrl #(
    parameter int LAT         = 2,
    parameter int RND_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    and_snina_ctrl_if.slave   bus
);
    localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int RCW = $clog2(RND_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RAND, ISSUE, WAIT, DONE, ALARM} state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [8:0]     ga_q, ga_d, gb_q, gb_d, oc_q, oc_d;
    logic [2:0]     gr_q, gr_d;
    logic           req_ready_q, req_ready_d;
    logic           rnd_req_q, rnd_req_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           alarm_q, alarm_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        gr_d    = gr_q;
        oc_d    = oc_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    ga_d    = {bus.req_a_2, bus.req_a_1, bus.req_a_0};
                    gb_d    = {bus.req_b_2, bus.req_b_1, bus.req_b_0};
                    rcnt_d  = '0;
                    state_d = RAND;
                end
            end
            RAND: begin
                // A mask arriving on the would-be timeout cycle wins over the alarm.
                if (bus.rnd_valid) begin
                    gr_d    = bus.rnd_data;
                    state_d = ISSUE;
                end else if (rcnt_q == RCW'(RND_TIMEOUT - 1)) begin
                    rcnt_d  = RCW'(RND_TIMEOUT);
                    state_d = ALARM;
                end else begin
                    rcnt_d  = rcnt_q + RCW'(1);
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == WCW'(LAT - 1)) begin
                    if (bus.g_ok_0 && bus.g_ok_1 && bus.g_ok_2) begin
                        oc_d    = {bus.g_c_2, bus.g_c_1, bus.g_c_0};
                        state_d = DONE;
                    end else begin
                        state_d = ALARM;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            ALARM: state_d = ALARM;
            default: state_d = ALARM;
        endcase

        // Nothing sensitive may remain visible once the block has alarmed.
        if (state_d == ALARM) begin
            ga_d = '0;
            gb_d = '0;
            gr_d = '0;
            oc_d = '0;
        end

        req_ready_d = (state_d == IDLE);
        rnd_req_d   = (state_d == RAND);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        alarm_d     = (state_d == ALARM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            ga_q        <= '0;
            gb_q        <= '0;
            gr_q        <= '0;
            oc_q        <= '0;
            req_ready_q <= 1'b1;
            rnd_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            ga_q        <= ga_d;
            gb_q        <= gb_d;
            gr_q        <= gr_d;
            oc_q        <= oc_d;
            req_ready_q <= req_ready_d;
            rnd_req_q   <= rnd_req_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rnd_req   = rnd_req_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.alarm     = alarm_q;
    assign bus.g_a_0     = ga_q[2:0];
    assign bus.g_a_1     = ga_q[5:3];
    assign bus.g_a_2     = ga_q[8:6];
    assign bus.g_b_0     = gb_q[2:0];
    assign bus.g_b_1     = gb_q[5:3];
    assign bus.g_b_2     = gb_q[8:6];
    assign bus.g_r       = gr_q;
    assign bus.out_c_0   = oc_q[2:0];
    assign bus.out_c_1   = oc_q[5:3];
    assign bus.out_c_2   = oc_q[8:6];
endmodule

// File: tb/tb_and_snina_ctrl.sv
// Randomized bench for and_snina_ctrl: a transaction-level timeline model predicts status,
// operand holding, result shares and alarm behaviour for every cycle of each operation.
module tb_and_snina_ctrl;
    localparam int LAT = 2;
    localparam int RT  = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    and_snina_ctrl_if bus();

    and_snina_ctrl #(.LAT(LAT), .RND_TIMEOUT(RT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit fault_ok1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Golden 3-share AND gadget on triplicated shares; r bits pair up the cross terms.
    function automatic logic [8:0] gadget(input logic [8:0] a, input logic [8:0] b, input logic [2:0] r);
        logic [2:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
        a0 = a[2:0]; a1 = a[5:3]; a2 = a[8:6];
        b0 = b[2:0]; b1 = b[5:3]; b2 = b[8:6];
        c0 = (a0 & b0) ^ (a0 & b1) ^ (a1 & b0) ^ {3{r[0]}} ^ {3{r[2]}};
        c1 = (a1 & b1) ^ (a1 & b2) ^ (a2 & b1) ^ {3{r[0]}} ^ {3{r[1]}};
        c2 = (a2 & b2) ^ (a0 & b2) ^ (a2 & b0) ^ {3{r[1]}} ^ {3{r[2]}};
        return {c2, c1, c0};
    endfunction

    function automatic logic [8:0] rand_shares();
        logic [2:0] s;
        s = 3'($urandom);
        return {{3{s[2]}}, {3{s[1]}}, {3{s[0]}}};
    endfunction

    logic [8:0] ga, gb, oc, gc;
    logic [2:0] gr;
    logic [4:0] st;
    assign ga = {bus.g_a_2, bus.g_a_1, bus.g_a_0};
    assign gb = {bus.g_b_2, bus.g_b_1, bus.g_b_0};
    assign gr = bus.g_r;
    assign oc = {bus.out_c_2, bus.out_c_1, bus.out_c_0};
    assign st = {bus.req_ready, bus.rnd_req, bus.out_valid, bus.busy, bus.alarm};

    assign gc         = gadget(ga, gb, gr);
    assign bus.g_c_0  = gc[2:0];
    assign bus.g_c_1  = gc[5:3];
    assign bus.g_c_2  = gc[8:6];
    assign bus.g_ok_0 = (gc[2:0] == 3'b000) || (gc[2:0] == 3'b111);
    assign bus.g_ok_1 = ((gc[5:3] == 3'b000) || (gc[5:3] == 3'b111)) && !fault_ok1;
    assign bus.g_ok_2 = (gc[8:6] == 3'b000) || (gc[8:6] == 3'b111);

    task automatic drive_junk();
        bus.req_valid = 1'($urandom);
        {bus.req_a_2, bus.req_a_1, bus.req_a_0} = rand_shares();
        {bus.req_b_2, bus.req_b_1, bus.req_b_0} = rand_shares();
        bus.rnd_valid = 1'($urandom);
        bus.rnd_data  = 3'($urandom);
        bus.out_ready = 1'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_status"}, 32'(st), 32'(5'b10000));
        chk({tag, "_g"}, 32'({ga, gb, gr}), 32'd0);
        chk({tag, "_outc"}, 32'(oc), 32'd0);
    endtask

    // Called at a negedge; asserts reset asynchronously and releases it on a later negedge.
    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check_reset_values("rst_async");
        repeat (n) begin
            @(negedge clk);
            drive_junk();
            check_reset_values("rst_hold");
        end
        @(negedge clk);
        reset     = 1'b1;
        fault_ok1 = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    // One operation. d = RAND cycles without a mask (>= RT means none), hold = extra DONE
    // cycles with out_ready low, abort_k >= 0 applies reset after that many edges.
    task automatic run_op(input logic [8:0] a, input logic [8:0] b, input logic [2:0] r,
                          input int d, input int hold, input bit fault, input int abort_k);
        int ra, dn, kend;
        logic [8:0] exp_c;
        logic [4:0] es;
        logic pa, pb;
        chk("req_ready_at_start", 32'(bus.req_ready), 32'd1);
        if (bus.req_ready !== 1'b1) return;
        bus.req_valid = 1'b1;
        {bus.req_a_2, bus.req_a_1, bus.req_a_0} = a;
        {bus.req_b_2, bus.req_b_1, bus.req_b_0} = b;
        bus.rnd_valid = 1'($urandom);
        bus.rnd_data  = 3'($urandom);
        bus.out_ready = 1'($urandom);
        ra    = d + 1;
        dn    = ra + 1 + LAT;
        kend  = (d >= RT) ? RT + 4 : (fault ? dn + 4 : dn + hold + 1);
        exp_c = gadget(a, b, r);
        pa    = a[0] ^ a[3] ^ a[6];
        pb    = b[0] ^ b[3] ^ b[6];
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            if (d >= RT)              es = (k < RT) ? 5'b01010 : 5'b00011;
            else if (k < ra)          es = 5'b01010;
            else if (k < dn)          es = 5'b00010;
            else if (fault)           es = 5'b00011;
            else if (k <= dn + hold)  es = 5'b00110;
            else                      es = 5'b10000;
            chk("status", 32'(st), 32'(es));
            if (es[0]) begin
                chk("alarm_g_zero", 32'({ga, gb, gr}), 32'd0);
                chk("alarm_outc_zero", 32'(oc), 32'd0);
            end else if (es[1] || (k >= ra && k < dn)) begin
                chk("g_operands", 32'({ga, gb}), 32'({a, b}));
                if (k >= ra) chk("g_r_held", 32'(gr), 32'(r));
            end
            if (es == 5'b00110) begin
                chk("out_c", 32'(oc), 32'(exp_c));
                if (k == dn) chk("out_c_xor", 32'(oc[2:0] ^ oc[5:3] ^ oc[8:6]), 32'({3{pa & pb}}));
            end
            if (k == abort_k) begin
                do_reset(2);
                return;
            end
            drive_junk();
            if (d < RT && k < ra) bus.rnd_valid = (k >= d);
            if (d >= RT && k < RT) bus.rnd_valid = 1'b0;
            if (k == d) bus.rnd_data = r;
            if (k >= dn) bus.out_ready = (k >= dn + hold);
            fault_ok1 = fault && (k == dn - 1);
            if (k == kend) bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0;
        {bus.req_a_2, bus.req_a_1, bus.req_a_0} = '0;
        {bus.req_b_2, bus.req_b_1, bus.req_b_0} = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset(5);

        // Nominal vector: a_0 = b_0 = 111, zero mask.
        run_op(9'b000_000_111, 9'b000_000_111, 3'b000, 0, 0, 1'b0, -1);
        // Backpressure for 10 cycles.
        run_op(rand_shares(), rand_shares(), 3'($urandom), 2, 10, 1'b0, -1);

        for (int i = 0; i < 20; i++)
            run_op(rand_shares(), rand_shares(), 3'($urandom),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0, -1);

        // Mask arriving on the 15th RAND cycle is accepted.
        run_op(rand_shares(), rand_shares(), 3'($urandom), RT - 1, 1, 1'b0, -1);
        // No mask at all: alarm after 15 RAND cycles, exited only by reset.
        run_op(rand_shares(), rand_shares(), 3'($urandom), RT, 0, 1'b0, -1);
        do_reset(2);

        // Consistency failure on the sampling cycle.
        run_op(rand_shares(), rand_shares(), 3'($urandom), 1, 0, 1'b1, -1);
        do_reset(2);

        // Reset during WAIT, then a normal operation.
        run_op(rand_shares(), rand_shares(), 3'($urandom), 0, 0, 1'b0, 2);
        run_op(9'b000_000_111, 9'b000_000_111, 3'b000, 0, 0, 1'b0, -1);
        run_op(rand_shares(), rand_shares(), 3'($urandom), 3, 2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/and_snina_ctrl.md
AND_SNINA_CTRL -- requirements
Module: and_snina_ctrl

Interface
REQ-001 Parameter LAT, default 2: gadget latency in clk cycles, from stable gadget inputs to valid gadget result and flags.
REQ-002 Parameter RND_TIMEOUT, default 15: maximum number of cycles spent waiting for randomness before the block alarms.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  operation request handshake.
REQ-006 req_a_0, req_a_1, req_a_2, req_b_0, req_b_1, req_b_2  in  3 each  operand shares; each share is triplicated across bits [2:0].
REQ-007 rnd_req / rnd_valid  out / in  1 / 1  randomness request handshake; rnd_data  in  3  fresh mask bits.
REQ-008 g_a_0..g_a_2, g_b_0..g_b_2, g_r  out  3 each  registered operands and mask driven to the AND gadget.
REQ-009 g_c_0..g_c_2  in  3 each  gadget result shares; g_ok_0..g_ok_2  in  1 each  gadget consistency flags, 1 = all replicas agree.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake; out_c_0..out_c_2  out  3 each  captured result shares.
REQ-011 busy  out  1  high in any state other than IDLE; alarm  out  1  sticky fault indication.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RAND, ISSUE, WAIT, DONE, ALARM.
REQ-013 req_ready SHALL be 1 only in IDLE.
REQ-014 On req_valid&req_ready, the block SHALL register all six operand shares into g_a_*/g_b_* and go to RAND.
REQ-015 In RAND, rnd_req SHALL be 1; on rnd_req&rnd_valid, the block SHALL register rnd_data into g_r and go to ISSUE.
REQ-016 ISSUE SHALL last exactly 1 cycle and then go to WAIT with the cycle counter cleared.
REQ-017 WAIT SHALL last exactly LAT cycles, counting up to LAT-1.
REQ-018 g_a_*, g_b_* and g_r SHALL be held constant from ISSUE entry to WAIT exit.
REQ-019 On the last WAIT cycle the block SHALL sample g_c_* and g_ok_*: if all three g_ok are 1, it SHALL register g_c_* into out_c_* and go to DONE; otherwise it SHALL go to ALARM.
REQ-020 In DONE, out_valid SHALL be 1 and out_c_* SHALL be stable until out_ready.
REQ-021 On out_valid&out_ready, the block SHALL return to IDLE, with req_ready rising on the next cycle (no same-cycle re-accept).
REQ-022 A RAND wait counter SHALL count cycles with rnd_valid=0; reaching RND_TIMEOUT SHALL go to ALARM, and the counter SHALL clear on RAND entry.
REQ-023 rnd_valid arriving in the same cycle the counter reaches RND_TIMEOUT SHALL be accepted; timeout SHALL not fire in that cycle.
REQ-024 In ALARM: alarm=1; req_ready, rnd_req, out_valid and busy logic unchanged (busy=1); g_* and out_c_* forced to 0.
REQ-025 ALARM SHALL be exited only by reset.
REQ-026 One operation at most SHALL be in flight; req_valid outside IDLE SHALL be ignored.
REQ-027 rnd_valid outside RAND SHALL be ignored and SHALL NOT consume randomness.
REQ-028 Counter widths SHALL be sized so that LAT-1 and RND_TIMEOUT are representable without wrap; a counter SHALL never wrap past its terminal value.

Reset
REQ-029 While reset=0: state=IDLE; req_ready=1; rnd_req=0; out_valid=0; busy=0; alarm=0; g_* and out_c_* = 0; both counters = 0.
REQ-030 Reset asserted mid-operation, in any state including ALARM, SHALL abort immediately, with no output handshake completed.
REQ-031 The first req accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-032 Scenario, reset: hold reset=0 with random inputs -> all outputs at REQ-029 values, req_ready=1.
REQ-033 Scenario, nominal: a_0=b_0=3'b111, other shares 0, rnd_data=3'b000, rnd_valid=1, golden gadget model, LAT=2, accept at edge t -> out_valid from edge t+4, out_c_0=3'b111, out_c_1=out_c_2=3'b000, alarm=0.
REQ-034 Scenario, backpressure: out_ready=0 for 10 cycles -> out_valid and out_c_* stable; req_ready=0; on out_ready=1, IDLE next cycle.
REQ-035 Scenario, fault: force g_ok_1=0 on the sampling cycle -> alarm=1 next cycle, out_valid never 1, outputs 0, new req_valid ignored until reset.
REQ-036 Scenario, timeout: rnd_valid=0 -> alarm after exactly 15 RAND cycles; rnd_valid=1 on the 15th cycle -> accepted, no alarm.
REQ-037 Scenario, reset during WAIT -> IDLE, all REQ-029 values, no out_valid pulse; the next request completes normally.
